// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_pkg
//  Description : Shared command codes, scan-code constants, FSM encodings and
//                expansion helpers for the PS/2 keyboard decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    localparam logic [6:0] CMD_HOME  = 7'h01;
    localparam logic [6:0] CMD_END   = 7'h04;
    localparam logic [6:0] CMD_BKSP  = 7'h08;
    localparam logic [6:0] CMD_TAB   = 7'h09;
    localparam logic [6:0] CMD_CRLF  = 7'h0D;
    localparam logic [6:0] CMD_LEFT  = 7'h11;
    localparam logic [6:0] CMD_RIGHT = 7'h12;
    localparam logic [6:0] CMD_DOWN  = 7'h13;
    localparam logic [6:0] CMD_SPC   = 7'h20;
    localparam logic [6:0] CMD_DEL   = 7'h7F;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [1:0] P_IDLE    = 2'd0;
    localparam logic [1:0] P_EXT     = 2'd1;
    localparam logic [1:0] P_BRK     = 2'd2;
    localparam logic [1:0] P_EXTBRK  = 2'd3;

    localparam logic [0:0] X_IDLE    = 1'b0;
    localparam logic [0:0] X_EMIT    = 1'b1;

    function automatic logic [6:0] extMap(input logic [7:0] code);
        case (code)
            8'h6C, 8'h7D, 8'h75: return CMD_HOME;
            8'h69, 8'h7A, 8'h72: return CMD_END;
            8'h6B:               return CMD_LEFT;
            8'h74:               return CMD_RIGHT;
            8'h71:               return CMD_DEL;
            8'h4A:               return 7'h2F;
            default:             return 7'h00;
        endcase
    endfunction

    function automatic logic isMulti(input logic [6:0] cmd);
        return (cmd == CMD_CRLF) || (cmd == CMD_TAB) || (cmd == CMD_DEL) || (cmd == CMD_BKSP);
    endfunction

    function automatic logic [3:0] expandLen(input logic [6:0] cmd, input logic [3:0] tabLen);
        case (cmd)
            CMD_CRLF: return 4'd2;
            CMD_TAB:  return tabLen;
            CMD_DEL:  return 4'd2;
            CMD_BKSP: return 4'd3;
            default:  return 4'd1;
        endcase
    endfunction

    function automatic logic [6:0] expandStep(input logic [6:0] cmd, input logic [3:0] step);
        case (cmd)
            CMD_CRLF: return (step == 4'd0) ? CMD_HOME : CMD_DOWN;
            CMD_TAB:  return CMD_SPC;
            CMD_DEL:  return (step == 4'd0) ? CMD_SPC : CMD_LEFT;
            CMD_BKSP: return (step == 4'd1) ? CMD_SPC : CMD_LEFT;
            default:  return cmd;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_if.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_if
//  Description : Scan-code input, keymap ROM and output handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface kbd_if;
    logic [7:0]  scan_code;
    logic        scan_valid;
    logic        rom_ce;
    logic [6:0]  rom_addr;
    logic [13:0] rom_dout;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic        caps_led;

    modport slave (
        input  scan_code, scan_valid, rom_dout, out_ready,
        output rom_ce, rom_addr, out_data, out_valid, overflow, caps_led
    );

    modport master (
        output scan_code, scan_valid, rom_dout, out_ready,
        input  rom_ce, rom_addr, out_data, out_valid, overflow, caps_led
    );
endinterface
`default_nettype wire

// File: rtl/kbd_scan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_scan_fifo
//  Description : Byte-wide scan-code FIFO with registered occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module kbd_scan_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_push,
    input  wire logic [7:0] i_pushData,
    input  wire logic       i_pop,
    output logic      [7:0] o_popData,
    output logic            o_full,
    output logic            o_empty
);
    localparam int c_ptrW = $clog2(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_ptrW-1:0] r_rdPtr;
    logic [c_ptrW:0]   r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign o_full    = (r_count == (c_ptrW + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_popData = r_mem[r_rdPtr];
    assign w_doPop   = i_pop && !o_empty;
    // A pop frees the slot the simultaneous push lands in, even when full.
    assign w_doPush  = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/kbd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_decoder
//  Description : PS/2 set-2 scan-code to ASCII/command decoder with modifier
//                tracking, keymap ROM lookup and command-sequence expansion.
//  Revision    : 1.0 - initial release
// ============================================================================
module kbd_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TAB_WIDTH   = 4,
    parameter bit CAPS_ENABLE = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset,
    kbd_if.slave      bus
);
    localparam logic [3:0] c_tabLen = 4'(TAB_WIDTH);

    logic [7:0] w_head;
    logic       w_full, w_empty, w_pop;
    logic [1:0] r_pState;
    logic       r_lshift, r_rshift, r_ctrl, r_alt, r_caps, r_capsHeld;
    logic       w_isExt, w_isBrk, w_isPrefix, w_isMod, w_romCe, w_direct;
    logic [6:0] w_extCode;
    logic       r_s2Valid, r_s2Rom;
    logic [6:0] r_s2Direct;
    logic [6:0] w_normal, w_shifted, w_sel, w_romChar, w_s2Code, w_srcCode;
    logic       w_lower, w_useShift, w_s2Has, w_canLoad, w_srcAlt, w_load;
    logic       r_holdValid, r_holdAlt;
    logic [6:0] r_holdCode;
    logic [0:0] r_xState;
    logic [6:0] r_xCmd;
    logic [3:0] r_step;
    logic [3:0] w_seqLen;
    logic [7:0] r_outData;
    logic       r_outValid, r_overflow;

    kbd_scan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (reset),
        .i_push     (bus.scan_valid),
        .i_pushData (bus.scan_code),
        .i_pop      (w_pop),
        .o_popData  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_isExt    = (r_pState == P_EXT) || (r_pState == P_EXTBRK);
    assign w_isBrk    = (r_pState == P_BRK) || (r_pState == P_EXTBRK);
    assign w_isPrefix = (w_head == SC_EXT) || (w_head == SC_BRK);
    assign w_isMod    = w_head inside {SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ALT, SC_CAPS};
    assign w_extCode  = extMap(w_head);

    // Popping is throttled so a stalled output never strands a ROM result.
    assign w_canLoad = (r_xState == X_IDLE) && (!r_outValid || bus.out_ready);
    assign w_pop     = !w_empty && (r_xState == X_IDLE) && !r_holdValid && !(r_s2Valid && !w_canLoad);
    assign w_romCe   = w_pop && !w_isPrefix && !w_isBrk && !w_isExt && !w_isMod && !w_head[7];
    assign w_direct  = w_pop && !w_isPrefix && !w_isBrk && w_isExt && (w_extCode != 7'd0);

    assign w_normal   = bus.rom_dout[6:0];
    assign w_shifted  = bus.rom_dout[13:7];
    assign w_lower    = (w_normal >= 7'h61) && (w_normal <= 7'h7A);
    assign w_useShift = (r_lshift | r_rshift) ^ (r_caps & w_lower);
    assign w_sel      = w_useShift ? w_shifted : w_normal;
    assign w_romChar  = (r_ctrl && w_sel[6]) ? (w_sel & 7'h1F) : w_sel;
    assign w_s2Code   = r_s2Rom ? w_romChar : r_s2Direct;
    assign w_s2Has    = r_s2Valid && (!r_s2Rom || (w_sel != 7'd0));

    assign w_srcCode  = r_holdValid ? r_holdCode : w_s2Code;
    assign w_srcAlt   = r_holdValid ? r_holdAlt : r_alt;
    assign w_load     = w_canLoad && (r_holdValid || w_s2Has);
    assign w_seqLen   = expandLen(r_xCmd, c_tabLen);

    assign bus.rom_ce    = w_romCe;
    assign bus.rom_addr  = w_romCe ? w_head[6:0] : 7'd0;
    assign bus.out_data  = r_outData;
    assign bus.out_valid = r_outValid;
    assign bus.overflow  = r_overflow;
    assign bus.caps_led  = r_caps;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pState   <= P_IDLE;
            r_lshift   <= 1'b0;
            r_rshift   <= 1'b0;
            r_ctrl     <= 1'b0;
            r_alt      <= 1'b0;
            r_caps     <= 1'b0;
            r_capsHeld <= 1'b0;
            r_overflow <= 1'b0;
            r_s2Valid  <= 1'b0;
            r_s2Rom    <= 1'b0;
            r_s2Direct <= 7'd0;
        end else begin
            r_overflow <= bus.scan_valid && w_full && !w_pop;
            r_s2Valid  <= w_romCe || w_direct;
            r_s2Rom    <= w_romCe;
            r_s2Direct <= w_extCode;
            if (w_pop) begin
                if (w_head == SC_EXT) begin
                    r_pState <= P_EXT;
                end else if (w_head == SC_BRK) begin
                    r_pState <= w_isExt ? P_EXTBRK : P_BRK;
                end else begin
                    r_pState <= P_IDLE;
                    if (!w_isExt && (w_head == SC_LSHIFT)) r_lshift <= !w_isBrk;
                    if (!w_isExt && (w_head == SC_RSHIFT)) r_rshift <= !w_isBrk;
                    if (w_head == SC_CTRL) r_ctrl <= !w_isBrk;
                    if (w_head == SC_ALT)  r_alt  <= !w_isBrk;
                    // Typematic repeats of CapsLock must not re-toggle.
                    if (CAPS_ENABLE && !w_isExt && (w_head == SC_CAPS)) begin
                        if (w_isBrk) begin
                            r_capsHeld <= 1'b0;
                        end else begin
                            if (!r_capsHeld) r_caps <= !r_caps;
                            r_capsHeld <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_holdValid <= 1'b0;
            r_holdCode  <= 7'd0;
            r_holdAlt   <= 1'b0;
            r_xState    <= X_IDLE;
            r_xCmd      <= 7'd0;
            r_step      <= 4'd0;
            r_outData   <= 8'd0;
            r_outValid  <= 1'b0;
        end else begin
            if (w_s2Has && (r_holdValid || !w_canLoad)) begin
                r_holdValid <= 1'b1;
                r_holdCode  <= w_s2Code;
                r_holdAlt   <= r_alt;
            end else if (w_load) begin
                r_holdValid <= 1'b0;
            end

            if (r_xState == X_EMIT) begin
                if (bus.out_ready) begin
                    if (r_step == w_seqLen) begin
                        r_xState   <= X_IDLE;
                        r_outValid <= 1'b0;
                        r_step     <= 4'd0;
                    end else begin
                        r_outData <= {r_outData[7], expandStep(r_xCmd, r_step)};
                        r_step    <= r_step + 4'd1;
                    end
                end
            end else if (w_load) begin
                r_outValid <= 1'b1;
                r_outData  <= {w_srcAlt, expandStep(w_srcCode, 4'd0)};
                if (isMulti(w_srcCode)) begin
                    r_xState <= X_EMIT;
                    r_xCmd   <= w_srcCode;
                    r_step   <= 4'd1;
                end
            end else if (bus.out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire
